par2ser_sched: RTL and testbench

Round-robin scheduler that shares one `par2ser` serializer among `NREQ` parallel-word requesters. It arbitrates pending requests, issues a one-cycle load with the winner's word, and frames the `DW` serial bit-times that follow. It sits between the word producers and the serializer, and supplies the frame and bit-index qualifiers consumed by the downstream Mealy detector.

---
 rtl/par2ser_pkg.sv | 16 +
 rtl/par2ser_sched_rr_arbiter.sv | 32 +++
 rtl/par2ser_sched.sv | 182 ++++++++++++++++++
 tb/tb_par2ser_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared state encodings and index-width helper for the par2ser scheduler slice.
package par2ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAR   = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/par2ser_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request after `last`, wrapping.
module rr_arbiter
  import par2ser_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh_c,
  output logic [IW-1:0]   win_idx_c
);

  logic        found;
  int unsigned j;

  always_comb begin
    win_oh_c  = '0;
    win_idx_c = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found       = 1'b1;
        win_oh_c[j] = 1'b1;
        win_idx_c   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/par2ser_sched.sv
// Round-robin scheduler sharing one par2ser serializer among NREQ requesters.
// Optional trailing even-parity slot when PAR2SER_SCHED_PARITY_EN is defined.
module par2ser_sched
  import par2ser_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idx_w(NREQ),
  localparam int unsigned BW  = idx_w(DW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic [IW-1:0]     owner,
  output logic              ld,
  output logic [DW-1:0]     ld_data,
  output logic              frame,
  output logic [BW-1:0]     bit_idx,
  output logic              busy,
  output logic              done
`ifdef PAR2SER_SCHED_PARITY_EN
  ,
  output logic              sel_par,
  output logic              par_bit
`endif
);

`ifdef PAR2SER_SCHED_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic            ld_q, ld_d;
  logic [DW-1:0]   ld_data_q, ld_data_d;
  logic            frame_q, frame_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef PAR2SER_SCHED_PARITY_EN
  logic            sel_par_q, sel_par_d;
  logic            par_bit_q, par_bit_d;
`endif

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            start;
  logic            take_grant;
  logic            end_frame;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req),
    .last      (last_q),
    .win_oh_c  (win_oh),
    .win_idx_c (win_idx)
  );

  assign start = en && (|req);

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    owner_d    = owner_q;
    last_d     = last_q;
    ld_d       = 1'b0;
    ld_data_d  = ld_data_q;
    frame_d    = 1'b0;
    bit_idx_d  = bit_idx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    take_grant = 1'b0;
    end_frame  = 1'b0;
`ifdef PAR2SER_SCHED_PARITY_EN
    sel_par_d  = 1'b0;
    par_bit_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: take_grant = start;
      ST_LOAD: begin
        state_d   = ST_SHIFT;
        frame_d   = 1'b1;
        busy_d    = 1'b1;
        bit_idx_d = BW'(DW - 1);
        done_d    = !PARITY && (DW == 1);
      end
      ST_SHIFT: begin
        if (bit_idx_q != '0) begin
          frame_d   = 1'b1;
          busy_d    = 1'b1;
          bit_idx_d = bit_idx_q - BW'(1);
          done_d    = !PARITY && (bit_idx_q == BW'(1));
        end else begin
`ifdef PAR2SER_SCHED_PARITY_EN
          state_d   = ST_PAR;
          frame_d   = 1'b1;
          busy_d    = 1'b1;
          sel_par_d = 1'b1;
          par_bit_d = ^ld_data_q;
          done_d    = 1'b1;
`else
          end_frame = 1'b1;
`endif
        end
      end
      ST_PAR:  end_frame = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // Last frame cycle re-arbitrates at the same edge so IDLE is skipped.
    if (end_frame) begin
      if (start) take_grant = 1'b1;
      else       state_d    = ST_IDLE;
    end

    if (take_grant) begin
      state_d   = ST_LOAD;
      gnt_d     = win_oh;
      owner_d   = win_idx;
      last_d    = win_idx;
      ld_d      = 1'b1;
      busy_d    = 1'b1;
      ld_data_d = din[32'(win_idx) * DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      ld_q      <= 1'b0;
      ld_data_q <= '0;
      frame_q   <= 1'b0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PAR2SER_SCHED_PARITY_EN
      sel_par_q <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      ld_q      <= ld_d;
      ld_data_q <= ld_data_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PAR2SER_SCHED_PARITY_EN
      sel_par_q <= sel_par_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign ld      = ld_q;
  assign ld_data = ld_data_q;
  assign frame   = frame_q;
  assign bit_idx = bit_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef PAR2SER_SCHED_PARITY_EN
  assign sel_par = sel_par_q;
  assign par_bit = par_bit_q;
`endif

endmodule

// File: tb/tb_par2ser_sched.sv
// Directed bench for par2ser_sched with a grant scoreboard and per-cycle frame monitor.
module tb_par2ser_sched;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned BW   = 3;
`ifdef PAR2SER_SCHED_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL = DW + PB;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   din;
  logic [NREQ-1:0]      gnt;
  logic [IW-1:0]        owner;
  logic                 ld;
  logic [DW-1:0]        ld_data;
  logic                 frame;
  logic [BW-1:0]        bit_idx;
  logic                 busy;
  logic                 done;
`ifdef PAR2SER_SCHED_PARITY_EN
  logic                 sel_par;
  logic                 par_bit;
`endif

  par2ser_sched #(.DW(DW), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .owner   (owner),
    .ld      (ld),
    .ld_data (ld_data),
    .frame   (frame),
    .bit_idx (bit_idx),
    .busy    (busy),
    .done    (done)
`ifdef PAR2SER_SCHED_PARITY_EN
    ,
    .sel_par (sel_par),
    .par_bit (par_bit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] who;
    logic [DW-1:0] word;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            prev_ld = -1;
  int            frames_left = 0;
  int            dones = 0;
  int            lds = 0;
  int            snap_d;
  int            snap_l;
  logic [BW-1:0] exp_bit;
  logic [DW-1:0] cur_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    din[i*DW +: DW] = w;
  endtask

  task automatic push(input int i, input logic [DW-1:0] w);
    exp_t e;
    e.who  = IW'(i);
    e.word = w;
    sb.push_back(e);
  endtask

  // One clock: sample #1 after the edge, score the cycle, then drop granted requests.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (ld) begin
      lds++;
      if (sb.size() == 0) begin
        check("unexpected_ld", 32'(ld), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ld_owner", 32'(owner), 32'(e.who));
        check("ld_data", 32'(ld_data), 32'(e.word));
        check("ld_gnt", 32'(gnt), 32'(NREQ'(1) << e.who));
        check("ld_busy", 32'(busy), 32'd1);
        check("ld_frame", 32'(frame), 32'd0);
        cur_word = e.word;
      end
      if (prev_ld >= 0) check("ld_period", 32'(cyc - prev_ld), 32'(DW + 1 + PB));
      prev_ld     = cyc;
      exp_bit     = BW'(DW - 1);
      frames_left = FL;
    end else if (frames_left > 0) begin
      check("frame_hi", 32'(frame), 32'd1);
      check("frame_busy", 32'(busy), 32'd1);
      check("frame_gnt", 32'(gnt), 32'd0);
      check("frame_ld_data", 32'(ld_data), 32'(cur_word));
`ifdef PAR2SER_SCHED_PARITY_EN
      if (frames_left == 1) begin
        check("par_sel", 32'(sel_par), 32'd1);
        check("par_bit", 32'(par_bit), 32'(^cur_word));
        check("par_done", 32'(done), 32'd1);
      end else begin
        check("shift_sel", 32'(sel_par), 32'd0);
        check("bit_idx", 32'(bit_idx), 32'(exp_bit));
        check("shift_done", 32'(done), 32'd0);
        exp_bit = exp_bit - BW'(1);
      end
`else
      check("bit_idx", 32'(bit_idx), 32'(exp_bit));
      check("shift_done", 32'(done), 32'(exp_bit == '0));
      exp_bit = exp_bit - BW'(1);
`endif
      if (done === 1'b1) dones++;
      frames_left--;
    end else begin
      check("idle_frame", 32'(frame), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    req = req & ~gnt;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    din = '0;

    // Reset holds every output low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_ld", 32'(ld), 32'd0);
    check("rst_ld_data", 32'(ld_data), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) cycle();
    check("idle_no_ld", 32'(lds), 32'd0);

    // Contention from reset: order 0,1,2,3 back to back.
    set_word(0, 8'h11);
    set_word(1, 8'h22);
    set_word(2, 8'h07);
    set_word(3, 8'h70);
    snap_d  = dones;
    prev_ld = -1;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h07); push(3, 8'h70);
    req = 4'b1111;
    repeat (4 * (FL + 1) + 4) cycle();
    check("cont_sb_empty", 32'(sb.size()), 32'd0);
    check("cont_dones", 32'(dones - snap_d), 32'd4);

    // Single request; din change after capture must not leak.
    set_word(1, 8'hA5);
    snap_d  = dones;
    prev_ld = -1;
    push(1, 8'hA5);
    req = 4'b0010;
    cycle();
    check("grant_latency", 32'(ld), 32'd1);
    set_word(1, 8'h00);
    repeat (FL + 3) cycle();
    check("single_sb_empty", 32'(sb.size()), 32'd0);
    check("single_dones", 32'(dones - snap_d), 32'd1);

    // Fairness: after serving 2, 0101 gives 0 then 2.
    prev_ld = -1;
    push(2, 8'h07);
    req = 4'b0100;
    repeat (FL + 3) cycle();
    prev_ld = -1;
    push(0, 8'h11); push(2, 8'h07);
    req = 4'b0101;
    repeat (2 * (FL + 1) + 3) cycle();
    check("fair_sb_empty", 32'(sb.size()), 32'd0);

    // en low blocks new grants.
    en     = 1'b0;
    snap_l = lds;
    req    = 4'b0010;
    repeat (5) cycle();
    check("en_low_no_ld", 32'(lds - snap_l), 32'd0);

    // en dropped mid-frame: frame completes, no further load.
    set_word(1, 8'h5C);
    snap_d  = dones;
    prev_ld = -1;
    push(1, 8'h5C);
    en = 1'b1;
    repeat (3) cycle();
    en  = 1'b0;
    req = 4'b1000;
    repeat (FL + 4) cycle();
    check("en_drop_dones", 32'(dones - snap_d), 32'd1);
    check("en_drop_lds", 32'(lds - snap_l), 32'd1);
    req = '0;
    en  = 1'b1;

    // Reset mid-frame at bit_idx 3.
    prev_ld = -1;
    push(3, 8'h70);
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (frame === 1'b1 && bit_idx === BW'(3)) break;
    end
    check("reach_idx3", 32'(bit_idx), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_frame", 32'(frame), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    frames_left = 0;
    snap_d      = dones;
    req         = 4'b1001;
    repeat (2) cycle();
    rst     = 1'b0;
    prev_ld = -1;
    push(0, 8'h11); push(3, 8'h70);
    repeat (2 * (FL + 1) + 4) cycle();
    check("rst_rec_sb_empty", 32'(sb.size()), 32'd0);
    check("rst_rec_dones", 32'(dones - snap_d), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
